// File: rtl/beam_trig_pkg.sv
// Shared configuration, derived datapath widths and helpers for the beam alignment trigger.
// Holds the default geometry: 4 beams, 8 channels, 8 samples per clock, 5-bit offset-binary samples.
package beam_trig_pkg;

    localparam int NBEAMS   = 4;
    localparam int NCHAN    = 8;
    localparam int NSAMP    = 8;
    localparam int NBITS    = 5;
    localparam int DEPTH    = 4;
    localparam int THRESH_W = 18;
    localparam int HOLDOFF  = 8;

    localparam int BEAM_W = $clog2(NBEAMS);
    localparam int CHAN_W = $clog2(NCHAN);
    localparam int DLY_W  = $clog2(DEPTH*NSAMP);
    localparam int SUM_W  = NBITS + $clog2(NCHAN);
    localparam int SQ_W   = 2*SUM_W;
    localparam int ACC_W  = SQ_W + $clog2(NSAMP);
    localparam int PWR_W  = (ACC_W > THRESH_W) ? ACC_W : THRESH_W;
    localparam int HOLD_W = $clog2(HOLDOFF+1);
    localparam int WCNT_W = $clog2(DEPTH+1);

    typedef logic [DLY_W-1:0] dly_t;
    localparam dly_t DLY_MAX = dly_t'((DEPTH-1)*NSAMP);

    typedef enum logic {WARMUP, RUN} state_t;

    function automatic logic signed [NBITS-1:0] offb_to_signed(input logic [NBITS-1:0] v);
        return {~v[NBITS-1], v[NBITS-2:0]};
    endfunction

endpackage

// File: rtl/beam_power_sum.sv
// One beam's power detector: channel sum and square are registered, the integrate/compare result is
// combinational into the caller's trigger register. No backpressure; accepts a new block every clock.
module beam_power_sum
    import beam_trig_pkg::*;
(
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NCHAN-1:0][NSAMP-1:0][NBITS-1:0] smp,
    input  logic [THRESH_W-1:0]                    thresh,
    output logic                                   hit
);

    localparam logic [THRESH_W-1:0] PWR_MAX = '1;

    logic signed [SUM_W-1:0] sum_d [NSAMP];
    logic signed [SUM_W-1:0] sum_q [NSAMP];
    logic [SQ_W-1:0]         sq_d  [NSAMP];
    logic [SQ_W-1:0]         sq_q  [NSAMP];
    logic [THRESH_W-1:0]     thr_s2_q;
    logic [THRESH_W-1:0]     thr_s3_q;
    logic [PWR_W-1:0]        acc;
    logic [THRESH_W-1:0]     pwr;

    always_comb begin
        for (int s = 0; s < NSAMP; s++) begin
            sum_d[s] = '0;
            for (int c = 0; c < NCHAN; c++)
                sum_d[s] = sum_d[s] + SUM_W'(offb_to_signed(smp[c][s]));
            sq_d[s] = SQ_W'($unsigned(int'(sum_q[s]) * int'(sum_q[s])));
        end
    end

    always_comb begin
        acc = '0;
        for (int s = 0; s < NSAMP; s++)
            acc = acc + PWR_W'(sq_q[s]);
        pwr = (acc > PWR_W'(PWR_MAX)) ? PWR_MAX : acc[THRESH_W-1:0];
    end

    // The threshold travels with its data so an update never affects blocks already in flight.
    assign hit = pwr > thr_s3_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < NSAMP; s++) begin
                sum_q[s] <= '0;
                sq_q[s]  <= '0;
            end
            thr_s2_q <= '1;
            thr_s3_q <= '1;
        end else begin
            sum_q    <= sum_d;
            sq_q     <= sq_d;
            thr_s2_q <= thresh;
            thr_s3_q <= thr_s2_q;
        end
    end

endmodule

// File: rtl/beam_align_trigger.sv
// Delay-and-sum beamformer trigger; 4 clocks data_i to trigger_o, no stalls, one result per beam per clock.
// Define BEAM_TRIG_HOLDOFF_EN to mask each beam for HOLDOFF clocks after it fires.
module beam_align_trigger
    import beam_trig_pkg::*;
(
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NCHAN-1:0][NSAMP*NBITS-1:0]  data_i,
    input  logic                               dly_wr_i,
    input  logic [BEAM_W-1:0]                  dly_beam_i,
    input  logic [CHAN_W-1:0]                  dly_chan_i,
    input  logic [DLY_W-1:0]                   dly_val_i,
    input  logic [THRESH_W-1:0]                thresh_i,
    input  logic [NBEAMS-1:0]                  thresh_ce_i,
    input  logic                               update_i,
    output logic                               dly_err_o,
    output logic [NBEAMS-1:0]                  trigger_o
);

    logic [NSAMP*NBITS-1:0] store_q [NCHAN][DEPTH];
    logic [NBITS-1:0]       hist    [NCHAN][DEPTH*NSAMP];
    logic [NCHAN-1:0][NSAMP-1:0][NBITS-1:0] aligned [NBEAMS];
    dly_t                   idx;

    dly_t                dly_sh_q  [NBEAMS][NCHAN];
    dly_t                dly_sh_d  [NBEAMS][NCHAN];
    dly_t                dly_act_q [NBEAMS][NCHAN];
    logic [THRESH_W-1:0] thr_sh_q  [NBEAMS];
    logic [THRESH_W-1:0] thr_sh_d  [NBEAMS];
    logic [THRESH_W-1:0] thr_act_q [NBEAMS];
    dly_t                dly_wr_val;

    logic [NBEAMS-1:0]   hit;
    state_t              state_q;
    logic [WCNT_W-1:0]   wcnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCHAN; c++)
                for (int a = 0; a < DEPTH; a++)
                    store_q[c][a] <= '0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                store_q[c][0] <= data_i[c];
                for (int a = 1; a < DEPTH; a++)
                    store_q[c][a] <= store_q[c][a-1];
            end
        end
    end

    // hist is a per-channel sample timeline, oldest at index 0; the undelayed block sits at the top.
    always_comb begin
        for (int c = 0; c < NCHAN; c++)
            for (int a = 0; a < DEPTH; a++)
                for (int s = 0; s < NSAMP; s++)
                    hist[c][(DEPTH-1-a)*NSAMP + s] = store_q[c][a][s*NBITS +: NBITS];
        idx = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            aligned[b] = '0;
            for (int c = 0; c < NCHAN; c++)
                for (int s = 0; s < NSAMP; s++) begin
                    idx = DLY_MAX + dly_t'(s) - dly_act_q[b][c];
                    aligned[b][c][s] = hist[c][idx];
                end
        end
    end

    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
        beam_power_sum u_beam_power_sum (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .smp    (aligned[b]),
            .thresh (thr_act_q[b]),
            .hit    (hit[b])
        );
    end

    assign dly_wr_val = (dly_val_i > DLY_MAX) ? DLY_MAX : dly_val_i;

    // Writes landing in the same cycle as update_i are folded into the copy via the _d view.
    always_comb begin
        dly_sh_d = dly_sh_q;
        thr_sh_d = thr_sh_q;
        if (dly_wr_i)
            dly_sh_d[dly_beam_i][dly_chan_i] = dly_wr_val;
        for (int b = 0; b < NBEAMS; b++)
            if (thresh_ce_i[b])
                thr_sh_d[b] = thresh_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NBEAMS; b++) begin
                for (int c = 0; c < NCHAN; c++) begin
                    dly_sh_q[b][c]  <= '0;
                    dly_act_q[b][c] <= '0;
                end
                thr_sh_q[b]  <= '1;
                thr_act_q[b] <= '1;
            end
            dly_err_o <= 1'b0;
        end else begin
            dly_sh_q <= dly_sh_d;
            thr_sh_q <= thr_sh_d;
            if (update_i) begin
                dly_act_q <= dly_sh_d;
                thr_act_q <= thr_sh_d;
            end
            if (dly_wr_i && (dly_val_i > DLY_MAX))
                dly_err_o <= 1'b1;
        end
    end

`ifdef BEAM_TRIG_HOLDOFF_EN
    logic [HOLD_W-1:0] hold_q [NBEAMS];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= WARMUP;
            wcnt_q    <= '0;
            trigger_o <= '0;
`ifdef BEAM_TRIG_HOLDOFF_EN
            for (int b = 0; b < NBEAMS; b++)
                hold_q[b] <= '0;
`endif
        end else begin
            case (state_q)
                WARMUP: begin
                    trigger_o <= '0;
                    wcnt_q    <= wcnt_q + 1'b1;
                    if (wcnt_q == WCNT_W'(DEPTH-1))
                        state_q <= RUN;
                end
                default: begin
`ifdef BEAM_TRIG_HOLDOFF_EN
                    for (int b = 0; b < NBEAMS; b++) begin
                        if (hold_q[b] != '0) begin
                            trigger_o[b] <= 1'b0;
                            hold_q[b]    <= hold_q[b] - 1'b1;
                        end else begin
                            trigger_o[b] <= hit[b];
                            if (hit[b])
                                hold_q[b] <= HOLD_W'(HOLDOFF);
                        end
                    end
`else
                    trigger_o <= hit;
`endif
                end
            endcase
        end
    end

endmodule
